lap_timer_core: RTL and testbench

Parametrised stopwatch core with lap memory and ordered playback; next generation of the three-key second counter. Counts a decimal BCD time value at a configurable tick rate, stores up to LAP_DEPTH lap captures in a small register file, and replays them oldest-first on request. Sits between the debounced key pulses and the display driver.

---
 rtl/lap_timer_pkg.sv | 24 ++
 rtl/lap_timer_core_bcd_counter.sv | 62 ++++++
 rtl/lap_timer_core.sv | 149 ++++++++++++++
 tb/tb_lap_timer_core.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/lap_timer_pkg.sv
// Shared types and helpers for the lap timer core: FSM states, BCD digit type,
// and the all-nines constant used to detect time-value wrap.
package lap_timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_PAUSE  = 2'd2,
    ST_RECALL = 2'd3
  } state_t;

  typedef logic [3:0] bcd_digit_t;

  // Returns a 32-bit word with the low `digits` nibbles set to 9.
  function automatic logic [31:0] bcd_all_nines(input int unsigned digits);
    logic [31:0] r;
    r = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (i < digits) r[4*i +: 4] = 4'd9;
    end
    return r;
  endfunction

endpackage

// File: rtl/lap_timer_core_bcd_counter.sv
// Multi-digit BCD up-counter with synchronous clear; wrap pulses on the
// increment that rolls all-nines over to all-zeros.
module bcd_counter
  import lap_timer_pkg::*;
#(
  parameter int unsigned DIGITS = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                inc,
  input  logic                clr,
  output logic [4*DIGITS-1:0] value,
  output logic                wrap
);

  localparam logic [31:0]         NINES32 = bcd_all_nines(DIGITS);
  localparam logic [4*DIGITS-1:0] NINES   = NINES32[4*DIGITS-1:0];

  logic [4*DIGITS-1:0] value_q;
  logic [4*DIGITS-1:0] inc_val;
  logic [4*DIGITS-1:0] value_d;

  always_comb begin
    logic       carry;
    bcd_digit_t d;
    inc_val = '0;
    carry   = 1'b1;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      d = value_q[4*i +: 4];
      if (carry) begin
        if (d == 4'd9) begin
          inc_val[4*i +: 4] = 4'd0;
        end else begin
          inc_val[4*i +: 4] = d + 4'd1;
          carry             = 1'b0;
        end
      end else begin
        inc_val[4*i +: 4] = d;
      end
    end
  end

  // Clear coincident with an increment restarts at one so no tick is lost.
  always_comb begin
    value_d = value_q;
    if (clr) begin
      value_d      = '0;
      value_d[3:0] = {3'b000, inc};
    end else if (inc) begin
      value_d = inc_val;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) value_q <= '0;
    else     value_q <= value_d;
  end

  assign value = value_q;
  assign wrap  = inc && !clr && (value_q == NINES);

endmodule

// File: rtl/lap_timer_core.sv
// Stopwatch core: BCD time counter, lap register file and oldest-first recall.
// Define LAP_TIMER_SPLIT_EN to store split times instead of cumulative times.
module lap_timer_core
  import lap_timer_pkg::*;
#(
  parameter int unsigned TICK_DIV  = 500000,
  parameter int unsigned DIGITS    = 6,
  parameter int unsigned LAP_DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start_stop_i,
  input  logic                         lap_i,
  input  logic                         recall_i,
  input  logic                         clear_i,
  output logic                         run_o,
  output logic [4*DIGITS-1:0]          disp_bcd_o,
  output logic                         recall_o,
  output logic [$clog2(LAP_DEPTH)-1:0] recall_idx_o,
  output logic [$clog2(LAP_DEPTH):0]   lap_count_o,
  output logic                         full_o,
  output logic                         wrap_o
);

  localparam int unsigned IW = $clog2(LAP_DEPTH);
  localparam int unsigned CW = IW + 1;
  localparam int unsigned DW = $clog2(TICK_DIV);
  localparam int unsigned W  = 4 * DIGITS;

  localparam logic [DW-1:0] DIV_LAST = DW'(TICK_DIV - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(LAP_DEPTH);

  state_t        state_q, state_d;
  state_t        saved_q, saved_d;
  state_t        base;
  logic [IW-1:0] idx_q, idx_d;
  logic [CW-1:0] cnt_q;
  logic [DW-1:0] div_q;
  logic          wrap_q;
  logic [W-1:0]  rd_q;
  logic [W-1:0]  lap_mem [LAP_DEPTH];

  logic         counting;
  logic         tick;
  logic         full;
  logic         lap_accept;
  logic [W-1:0] live_val;
  logic         live_wrap;
  logic [W-1:0] lap_data;

  assign counting   = (state_q == ST_RUN) || (state_q == ST_RECALL && saved_q == ST_RUN);
  assign tick       = counting && (div_q == DIV_LAST) && !clear_i;
  assign full       = (cnt_q == FULL_CNT);
  assign lap_accept = lap_i && !clear_i && (state_q != ST_IDLE) && !full;

  bcd_counter #(.DIGITS(DIGITS)) u_live (
    .clk   (clk),
    .rst   (rst),
    .inc   (tick),
    .clr   (clear_i),
    .value (live_val),
    .wrap  (live_wrap)
  );

`ifdef LAP_TIMER_SPLIT_EN
  logic [W-1:0] split_val;
  logic         split_wrap_unused;

  bcd_counter #(.DIGITS(DIGITS)) u_split (
    .clk   (clk),
    .rst   (rst),
    .inc   (tick),
    .clr   (clear_i || lap_accept),
    .value (split_val),
    .wrap  (split_wrap_unused)
  );

  assign lap_data = split_val;
`else
  assign lap_data = live_val;
`endif

  // Priority chain: clear > start_stop > lap > recall. A lap coincident with
  // start_stop is handled separately through lap_accept.
  always_comb begin
    state_d = state_q;
    saved_d = saved_q;
    idx_d   = idx_q;
    base    = (state_q == ST_RECALL) ? saved_q : state_q;
    if (clear_i) begin
      state_d = ST_IDLE;
      idx_d   = '0;
    end else if (start_stop_i) begin
      state_d = (base == ST_RUN) ? ST_PAUSE : ST_RUN;
      idx_d   = '0;
    end else if (lap_i) begin
      state_d = state_q;
    end else if (recall_i) begin
      if (state_q == ST_RECALL) begin
        if ({1'b0, idx_q} == cnt_q - 1'b1) begin
          state_d = saved_q;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end else if (cnt_q != '0) begin
        saved_d = state_q;
        state_d = ST_RECALL;
        idx_d   = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      saved_q <= ST_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      div_q   <= '0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      saved_q <= saved_d;
      idx_q   <= idx_d;
      if (clear_i)         cnt_q <= '0;
      else if (lap_accept) cnt_q <= cnt_q + 1'b1;
      if (clear_i)       div_q <= '0;
      else if (counting) div_q <= (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
      if (clear_i)        wrap_q <= 1'b0;
      else if (live_wrap) wrap_q <= 1'b1;
    end
  end

  // Lap storage is not reset; lap_count bounds what is ever shown.
  always_ff @(posedge clk) begin
    if (lap_accept && !rst) lap_mem[cnt_q[IW-1:0]] <= lap_data;
    rd_q <= lap_mem[idx_d];
  end

  assign run_o        = counting;
  assign recall_o     = (state_q == ST_RECALL);
  assign disp_bcd_o   = recall_o ? rd_q : live_val;
  assign recall_idx_o = idx_q;
  assign lap_count_o  = cnt_q;
  assign full_o       = full;
  assign wrap_o       = wrap_q;

endmodule

// File: tb/tb_lap_timer_core.sv
// Self-checking bench for lap_timer_core (TICK_DIV=4, DIGITS=4, LAP_DEPTH=4);
// honours LAP_TIMER_SPLIT_EN for the stored-slot expectations.
module tb_lap_timer_core;

  logic        clk = 1'b0;
  logic        rst, start_stop_i, lap_i, recall_i, clear_i;
  logic        run_o, recall_o, full_o, wrap_o;
  logic [15:0] disp_bcd_o;
  logic [1:0]  recall_idx_o;
  logic [2:0]  lap_count_o;

  int unsigned n_total = 0;
  int unsigned n_pass  = 0;
  int unsigned t       = 0;

  lap_timer_core #(.TICK_DIV(4), .DIGITS(4), .LAP_DEPTH(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .start_stop_i (start_stop_i),
    .lap_i        (lap_i),
    .recall_i     (recall_i),
    .clear_i      (clear_i),
    .run_o        (run_o),
    .disp_bcd_o   (disp_bcd_o),
    .recall_o     (recall_o),
    .recall_idx_o (recall_idx_o),
    .lap_count_o  (lap_count_o),
    .full_o       (full_o),
    .wrap_o       (wrap_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        ss, lap, rec, clr;
    logic        run, rcl;
    logic [1:0]  idx;
    logic [2:0]  cnt;
    logic [15:0] disp;
  } vec_t;

  vec_t        vecs [12];
  vec_t        sb [$];
  logic [15:0] slot_exp [4];
  int unsigned lap_vals [5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0d)", name, act, exp, t);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    t++;
  endtask

  task automatic pulse(input logic ss, input logic lp, input logic rc, input logic cl);
    start_stop_i = ss; lap_i = lp; recall_i = rc; clear_i = cl;
    step();
    start_stop_i = 1'b0; lap_i = 1'b0; recall_i = 1'b0; clear_i = 1'b0;
  endtask

  task automatic run_to(input int unsigned target);
    while (t < target) step();
  endtask

  initial begin
    vec_t e;
    rst = 1'b1; start_stop_i = 1'b0; lap_i = 1'b0; recall_i = 1'b0; clear_i = 1'b0;
`ifdef LAP_TIMER_SPLIT_EN
    slot_exp = '{16'h0003, 16'h0004, 16'h0005, 16'h0008};
`else
    slot_exp = '{16'h0003, 16'h0007, 16'h0012, 16'h0020};
`endif
    lap_vals = '{3, 7, 12, 20, 25};

    // Recall walk from PAUSE at 0x0025 with divider phase 3, then resume.
    vecs[0]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 3'd4, slot_exp[0]};
    vecs[1]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'd1, 3'd4, slot_exp[1]};
    vecs[2]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'd2, 3'd4, slot_exp[2]};
    vecs[3]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'd3, 3'd4, slot_exp[3]};
    vecs[4]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 3'd4, 16'h0025};
    vecs[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 3'd4, 16'h0025};
    vecs[6]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 3'd4, slot_exp[0]};
    vecs[7]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 3'd4, slot_exp[0]};
    vecs[8]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 3'd4, 16'h0025};
    vecs[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 3'd4, 16'h0026};
    vecs[10] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 2'd0, 3'd4, slot_exp[0]};
    vecs[11] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 3'd4, 16'h0026};

    // Reset state
    step(); step();
    rst = 1'b0;
    chk("rst_run", run_o, 0);
    chk("rst_disp", disp_bcd_o, 0);
    chk("rst_recall", recall_o, 0);
    chk("rst_idx", recall_idx_o, 0);
    chk("rst_cnt", lap_count_o, 0);
    chk("rst_full", full_o, 0);
    chk("rst_wrap", wrap_o, 0);

    // Run 40 cycles, then pause and hold
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    t = 0;
    chk("start_run", run_o, 1);
    chk("start_disp", disp_bcd_o, 16'h0000);
    run_to(39);
    chk("run_39", disp_bcd_o, 16'h0009);
    step();
    chk("run_40", disp_bcd_o, 16'h0010);
    chk("run_40_run", run_o, 1);
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    chk("pause_run", run_o, 0);
    repeat (100) step();
    chk("pause_hold", disp_bcd_o, 16'h0010);

    // Clear, lap ignored in IDLE, then five laps into four slots
    pulse(1'b0, 1'b0, 1'b0, 1'b1);
    chk("clr_disp", disp_bcd_o, 0);
    chk("clr_run", run_o, 0);
    pulse(1'b0, 1'b1, 1'b0, 1'b0);
    chk("idle_lap_cnt", lap_count_o, 0);
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    t = 0;
    for (int i = 0; i < 5; i++) begin
      run_to(4 * lap_vals[i] + 1);
      pulse(1'b0, 1'b1, 1'b0, 1'b0);
      chk("lap_cnt", lap_count_o, (i < 4) ? i + 1 : 4);
      chk("lap_full", full_o, (i >= 3) ? 1 : 0);
    end
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    chk("lap_pause_disp", disp_bcd_o, 16'h0025);

    // Table vectors through a scoreboard queue
    for (int i = 0; i < 12; i++) begin
      start_stop_i = vecs[i].ss; lap_i = vecs[i].lap;
      recall_i = vecs[i].rec; clear_i = vecs[i].clr;
      sb.push_back(vecs[i]);
      step();
      start_stop_i = 1'b0; lap_i = 1'b0; recall_i = 1'b0; clear_i = 1'b0;
      e = sb.pop_front();
      chk($sformatf("v%0d_run", i), run_o, e.run);
      chk($sformatf("v%0d_recall", i), recall_o, e.rcl);
      chk($sformatf("v%0d_idx", i), recall_idx_o, e.idx);
      chk($sformatf("v%0d_cnt", i), lap_count_o, e.cnt);
      chk($sformatf("v%0d_disp", i), disp_bcd_o, e.disp);
    end

    // clear + lap + start_stop together
    pulse(1'b1, 1'b1, 1'b0, 1'b1);
    chk("ccl_run", run_o, 0);
    chk("ccl_cnt", lap_count_o, 0);
    chk("ccl_full", full_o, 0);
    chk("ccl_disp", disp_bcd_o, 0);

    // lap + start_stop in IDLE: lap ignored; in RUN: lap stored then pause
    pulse(1'b1, 1'b1, 1'b0, 1'b0);
    t = 0;
    chk("idle_ls_run", run_o, 1);
    chk("idle_ls_cnt", lap_count_o, 0);
    run_to(9);
    pulse(1'b1, 1'b1, 1'b0, 1'b0);
    chk("run_ls_run", run_o, 0);
    chk("run_ls_cnt", lap_count_o, 1);
    pulse(1'b0, 1'b0, 1'b1, 1'b0);
    chk("run_ls_slot", disp_bcd_o, 16'h0002);
    chk("run_ls_recall", recall_o, 1);
    pulse(1'b0, 1'b0, 1'b1, 1'b0);
    chk("recall_exit", recall_o, 0);
    chk("recall_exit_run", run_o, 0);

    // Reset during RECALL with background running
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    pulse(1'b0, 1'b0, 1'b1, 1'b0);
    chk("bg_recall", recall_o, 1);
    chk("bg_run", run_o, 1);
    rst = 1'b1; recall_i = 1'b1; start_stop_i = 1'b1;
    step();
    rst = 1'b0; recall_i = 1'b0; start_stop_i = 1'b0;
    chk("mid_rst_run", run_o, 0);
    chk("mid_rst_recall", recall_o, 0);
    chk("mid_rst_cnt", lap_count_o, 0);
    chk("mid_rst_disp", disp_bcd_o, 0);
    pulse(1'b0, 1'b0, 1'b1, 1'b0);
    chk("empty_recall", recall_o, 0);

    // Wrap past all-nines
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    t = 0;
    run_to(4 * 9998 + 1);
    chk("pre_wrap", disp_bcd_o, 16'h9998);
    chk("pre_wrap_flag", wrap_o, 0);
    run_to(4 * 9999);
    chk("nines", disp_bcd_o, 16'h9999);
    run_to(4 * 10000);
    chk("wrapped", disp_bcd_o, 16'h0000);
    chk("wrap_flag", wrap_o, 1);
    pulse(1'b0, 1'b0, 1'b0, 1'b1);
    chk("wrap_clr", wrap_o, 0);
    repeat (8) step();
    chk("wrap_clr_idle", run_o, 0);
    chk("wrap_clr_disp", disp_bcd_o, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
